// File: rtl/seqdet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seqdet_pkg
//  Description : Shared types and defaults for the BRAM scan sequencer and its
//                pattern-match window. Holds the scan FSM state encoding, the
//                default pattern and the match-counter sizing that suits a
//                4-digit decimal display.
//  Revision    : 1.0 - initial release
// ============================================================================
package seqdet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_t;

    localparam int         SEQ_PAT_LEN = 4;
    localparam logic [3:0] SEQ_PATTERN = 4'b1011;
    localparam int         SEQ_CNT_W   = 14;
    // Largest value a 4-digit decimal display can show.
    localparam int         SEQ_CNT_MAX = 9999;

endpackage : seqdet_pkg
`default_nettype wire

// File: rtl/seq_match_window.sv
`default_nettype none
// ============================================================================
//  Module      : seq_match_window
//  Description : Overlapping serial pattern matcher. Keeps the last PAT_LEN-1
//                bits and a saturating fill count; hit is asserted while shift
//                is high and the incoming bit completes PATTERN (MSB = oldest).
//  Ports       : clk      - clock
//                reset_n  - asynchronous active-low reset
//                clr      - synchronous clear of window and fill count
//                shift    - accept bit_in this cycle
//                bit_in   - serial data bit
//                hit      - combinational match strobe for the current shift
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_match_window
    import seqdet_pkg::*;
#(
    parameter int                 PAT_LEN = SEQ_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = SEQ_PATTERN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic shift,
    input  logic bit_in,
    output logic hit
);

    localparam int                  c_FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PAT_LEN);
    localparam logic [c_FILL_W-1:0] c_FILL_ARM  = c_FILL_W'(PAT_LEN - 1);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE  = c_FILL_W'(1);

    // Only PAT_LEN-1 history bits are stored; the newest bit is the live input.
    logic [PAT_LEN-2:0]  r_win;
    logic [c_FILL_W-1:0] r_fill;
    logic [PAT_LEN-1:0]  w_cand;

    assign w_cand = {r_win, bit_in};
    assign hit    = shift && (r_fill >= c_FILL_ARM) && (w_cand == PATTERN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_win  <= '0;
            r_fill <= '0;
        end else if (shift) begin
            // Window is never flushed on a hit, so matches may overlap.
            r_win <= w_cand[PAT_LEN-2:0];
            if (r_fill != c_FILL_FULL) begin
                r_fill <= r_fill + c_FILL_ONE;
            end
        end
    end

endmodule : seq_match_window
`default_nettype wire

// File: rtl/bram_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bram_scan_sequencer
//  Description : Walks a block RAM one bit at a time from a captured base
//                address, waits out the read latency, and feeds each bit to an
//                overlapping pattern matcher. Counts matches with saturation.
//  Ports       : clock_100Mhz, reset_n (async, active-low)
//                start, base_addr, length  - scan request (sampled in IDLE)
//                step_en                   - per-bit advance permission
//                mem_en, mem_addr, mem_dout - BRAM read port
//                busy, done                - scan handshake
//                match_count, match_pulse, overflow - match results
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_scan_sequencer
    import seqdet_pkg::*;
#(
    parameter int                 ADDR_W  = 4,
    parameter int                 MEM_LAT = 1,
    parameter int                 PAT_LEN = SEQ_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = SEQ_PATTERN,
    parameter int                 CNT_W   = SEQ_CNT_W,
    parameter int                 CNT_MAX = SEQ_CNT_MAX
) (
    input  logic              clock_100Mhz,
    input  logic              reset_n,
    input  logic              start,
    input  logic              step_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_dout,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_count,
    output logic              match_pulse,
    output logic              overflow
);

    localparam int                 c_LAT_W     = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [c_LAT_W-1:0] c_WAIT_LAST = c_LAT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam logic [c_LAT_W-1:0] c_WAIT_ONE  = c_LAT_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]    c_IDX_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0]  c_PTR_ONE   = ADDR_W'(1);

    scan_state_t         r_state;
    scan_state_t         w_state_next;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_idx;
    logic [ADDR_W-1:0]   r_ptr;        // base + idx, wraps naturally at DEPTH
    logic [c_LAT_W-1:0]  r_wait;
    logic                r_mem_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_count;
    logic                r_pulse;
    logic                r_overflow;

    logic                w_start_any;
    logic                w_accept;
    logic                w_sample;
    logic                w_last;
    logic                w_issue;
    logic                w_hit;
    logic [ADDR_W:0]     w_idx_inc;
    logic [ADDR_W-1:0]   w_fetch_addr;

    assign w_start_any = (r_state == ST_IDLE) && start;
    assign w_accept    = w_start_any && (length != '0);
    assign w_sample    = (r_state == ST_SAMPLE);
    assign w_idx_inc   = r_idx + c_IDX_ONE;
    assign w_last      = (w_idx_inc == r_len);

    // mem_en is a flop: a read issues in the FETCH cycle whose step
    // permission was seen on the edge that entered (or held) FETCH.
    assign w_issue      = (w_state_next == ST_FETCH) && step_en;
    assign w_fetch_addr = w_accept ? base_addr :
                          (w_sample ? r_ptr + c_PTR_ONE : r_ptr);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (length == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (r_mem_en) begin
                    w_state_next = (MEM_LAT > 1) ? ST_WAIT : ST_SAMPLE;
                end
            end
            ST_WAIT: begin
                if (r_wait == c_WAIT_LAST) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_state_next = w_last ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_wait     <= '0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
            r_pulse    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_busy   <= (w_state_next == ST_FETCH) || (w_state_next == ST_WAIT) ||
                        (w_state_next == ST_SAMPLE);
            r_done   <= (w_state_next == ST_DONE);
            r_mem_en <= w_issue;
            if (w_issue) begin
                r_mem_addr <= w_fetch_addr;
            end

            if (w_accept) begin
                r_len <= length;
                r_idx <= '0;
                r_ptr <= base_addr;
            end else if (w_sample) begin
                r_idx <= w_idx_inc;
                r_ptr <= r_ptr + c_PTR_ONE;
            end

            r_wait <= (r_state == ST_WAIT) ? r_wait + c_WAIT_ONE : '0;

            r_pulse <= w_hit;
            if (w_start_any) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (w_hit) begin
                if (r_count < c_CNT_MAX) begin
                    r_count <= r_count + c_CNT_ONE;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    seq_match_window #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_window (
        .clk     (clock_100Mhz),
        .reset_n (reset_n),
        .clr     (w_start_any),
        .shift   (w_sample),
        .bit_in  (mem_dout),
        .hit     (w_hit)
    );

    assign mem_en      = r_mem_en;
    assign mem_addr    = r_mem_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign match_count = r_count;
    assign match_pulse = r_pulse;
    assign overflow    = r_overflow;

endmodule : bram_scan_sequencer
`default_nettype wire

// File: tb/tb_bram_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_scan_sequencer
//  Description : Self-checking bench for bram_scan_sequencer with a behavioural
//                BRAM of latency MEM_LAT and a scoreboard of expected read
//                addresses and per-scan results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_scan_sequencer;

    localparam int MEM_LAT = 2;
    localparam int CMAX    = 4;
    localparam int BUDGET  = 400;

    typedef struct {
        int cnt;
        int ov;
        int pulses;
        int done_k;
        int len;
    } res_t;

    logic        clock_100Mhz = 1'b0;
    logic        reset_n      = 1'b0;
    logic        start        = 1'b0;
    logic        step_en      = 1'b1;
    logic [3:0]  base_addr    = '0;
    logic [4:0]  length       = '0;
    logic        mem_en;
    logic [3:0]  mem_addr;
    logic        mem_dout     = 1'b0;
    logic        busy;
    logic        done;
    logic [13:0] match_count;
    logic        match_pulse;
    logic        overflow;

    logic [15:0] mem = '0;
    logic        r_pipe1 = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int n_mem_en = 0;
    int n_pulse  = 0;
    int q_addr[$];
    res_t q_res[$];

    always #5 clock_100Mhz = ~clock_100Mhz;

    bram_scan_sequencer #(
        .ADDR_W  (4),
        .MEM_LAT (MEM_LAT),
        .PAT_LEN (4),
        .PATTERN (4'b1011),
        .CNT_W   (14),
        .CNT_MAX (CMAX)
    ) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset_n      (reset_n),
        .start        (start),
        .step_en      (step_en),
        .base_addr    (base_addr),
        .length       (length),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_dout     (mem_dout),
        .busy         (busy),
        .done         (done),
        .match_count  (match_count),
        .match_pulse  (match_pulse),
        .overflow     (overflow)
    );

    // Two-stage BRAM read pipe: data for an address presented in cycle c is
    // on mem_dout during cycle c+2.
    always @(posedge clock_100Mhz) begin
        r_pipe1  <= mem_en ? mem[mem_addr] : 1'b0;
        mem_dout <= r_pipe1;
    end

    // Read-address scoreboard and event counters.
    always @(negedge clock_100Mhz) begin
        if (reset_n) begin
            if (mem_en) begin
                n_mem_en++;
                checks++;
                if (q_addr.size() == 0) begin
                    errors++;
                    $display("FAIL mem_addr unexpected read got=%0d want=none", mem_addr);
                end else begin
                    int exp_a;
                    exp_a = q_addr.pop_front();
                    if (mem_addr !== 4'(exp_a)) begin
                        errors++;
                        $display("FAIL mem_addr got=%0d want=%0d", mem_addr, exp_a);
                    end
                end
            end
            if (match_pulse) n_pulse++;
        end
    end

    function automatic void model(input int base, input int len,
                                  output int cnt, output int ov, output int pulses);
        logic [3:0] w;
        int fill;
        w = '0; fill = 0; cnt = 0; ov = 0; pulses = 0;
        for (int i = 0; i < len; i++) begin
            w = {w[2:0], mem[(base + i) % 16]};
            if (fill < 4) fill++;
            if (fill >= 4 && w == 4'b1011) begin
                pulses++;
                if (cnt < CMAX) cnt++;
                else ov = 1;
            end
        end
    endfunction

    task automatic run_scan(input int base, input int len, input int period,
                            input bit poke, input string name);
        int   cnt, ov, pul, n_step, k_done;
        bit   seen;
        res_t r, e;
        model(base, len, cnt, ov, pul);
        r.cnt = cnt; r.ov = ov; r.pulses = pul; r.len = len;
        r.done_k = 1 + len * (1 + MEM_LAT);
        q_res.push_back(r);
        for (int i = 0; i < len; i++) q_addr.push_back((base + i) % 16);
        n_step = 0; seen = 0; k_done = 0;

        @(negedge clock_100Mhz);
        n_mem_en = 0; n_pulse = 0;
        start = 1'b1; base_addr = 4'(base); length = 5'(len);
        step_en = (period == 0);
        @(posedge clock_100Mhz);
        #1 start = 1'b0;

        for (int k = 1; k <= BUDGET && !seen; k++) begin
            @(negedge clock_100Mhz);
            if (k == 1) begin
                checks++;
                if (busy !== (len != 0)) begin
                    errors++;
                    $display("FAIL %s busy_after_start got=%b want=%b", name, busy, (len != 0));
                end
                checks++;
                if (match_count !== 14'd0 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL %s start_clear got count=%0d ov=%b want count=0 ov=0",
                             name, match_count, overflow);
                end
            end
            if (done) begin
                seen = 1; k_done = k;
                #1;
                e = q_res.pop_front();
                if (period == 0) begin
                    checks++;
                    if (k_done != e.done_k) begin
                        errors++;
                        $display("FAIL %s done_cycle got=%0d want=%0d", name, k_done, e.done_k);
                    end
                end
                checks++;
                if (match_count !== 14'(e.cnt) || overflow !== 1'(e.ov)) begin
                    errors++;
                    $display("FAIL %s result got count=%0d ov=%b want count=%0d ov=%0d",
                             name, match_count, overflow, e.cnt, e.ov);
                end
                checks++;
                if (n_pulse != e.pulses) begin
                    errors++;
                    $display("FAIL %s match_pulses got=%0d want=%0d", name, n_pulse, e.pulses);
                end
                checks++;
                if (n_mem_en != e.len || q_addr.size() != 0) begin
                    errors++;
                    $display("FAIL %s reads got=%0d want=%0d pending=%0d",
                             name, n_mem_en, e.len, q_addr.size());
                end
                if (period != 0) begin
                    checks++;
                    if (n_step != n_mem_en) begin
                        errors++;
                        $display("FAIL %s reads_per_step got=%0d want=%0d", name, n_mem_en, n_step);
                    end
                end
            end else begin
                if (period != 0) begin
                    step_en = (k % period == 0);
                    if (step_en) n_step++;
                end
                if (poke) begin
                    start     = (k == 5);
                    base_addr = (k == 5) ? 4'd9 : 4'(base);
                    length    = (k == 5) ? 5'd3 : 5'(len);
                end
            end
        end

        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s done_timeout got=none want=done within %0d cycles", name, BUDGET);
            void'(q_res.pop_front());
            q_addr.delete();
        end

        start = 1'b0; step_en = 1'b1;
        @(negedge clock_100Mhz);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || match_count !== 14'(cnt)) begin
            errors++;
            $display("FAIL %s after_done got busy=%b done=%b count=%0d want busy=0 done=0 count=%0d",
                     name, busy, done, match_count, cnt);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock_100Mhz);
        checks++;
        if (mem_en !== 1'b0 || mem_addr !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got en=%b addr=%0d busy=%b done=%b want all 0",
                     mem_en, mem_addr, busy, done);
        end
        checks++;
        if (match_count !== 14'd0 || match_pulse !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_result got count=%0d pulse=%b ov=%b want all 0",
                     match_count, match_pulse, overflow);
        end
        reset_n = 1'b1;
        @(negedge clock_100Mhz);
    endtask

    task automatic test_basic();
        mem = '0;
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = 7'b1011011;
        run_scan(0, 7, 0, 1'b0, "basic");
    endtask

    task automatic test_zero_length();
        run_scan(3, 0, 0, 1'b0, "zero_len");
    endtask

    task automatic test_wrap();
        mem = '0;
        mem[14] = 1'b1; mem[15] = 1'b0; mem[0] = 1'b1; mem[1] = 1'b1;
        run_scan(14, 4, 0, 1'b0, "wrap");
    endtask

    task automatic test_step_pulsed();
        mem = '0;
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = 7'b1011011;
        run_scan(0, 7, 8, 1'b1, "step_pulsed");
    endtask

    task automatic test_saturation();
        mem = '0;
        for (int i = 0; i < 16; i++) mem[i] = ((i % 3) != 1);
        run_scan(0, 13, 0, 1'b0, "at_max");
        run_scan(0, 16, 0, 1'b0, "saturate");
        run_scan(0, 4, 0, 1'b0, "clear_after_sat");
    endtask

    task automatic test_reset_mid_scan();
        bit armed;
        mem = '0;
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6]} = 7'b1011011;
        for (int i = 0; i < 7; i++) q_addr.push_back(i);
        @(negedge clock_100Mhz);
        n_mem_en = 0; n_pulse = 0;
        start = 1'b1; base_addr = 4'd0; length = 5'd7; step_en = 1'b1;
        @(posedge clock_100Mhz);
        #1 start = 1'b0;
        armed = 0;
        for (int k = 0; k < BUDGET && !armed; k++) begin
            @(negedge clock_100Mhz);
            #1;
            if (n_pulse >= 1 && mem_en) armed = 1;
        end
        checks++;
        if (!armed) begin
            errors++;
            $display("FAIL reset_mid arm got=no_read_after_match want=read_after_match");
        end
        @(posedge clock_100Mhz);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0 || match_count !== 14'd0 ||
            done !== 1'b0 || overflow !== 1'b0 || match_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b en=%b count=%0d done=%b ov=%b pulse=%b want all 0",
                     busy, mem_en, match_count, done, overflow, match_pulse);
        end
        q_addr.delete();
        @(negedge clock_100Mhz);
        reset_n = 1'b1;
        run_scan(0, 7, 0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_wrap();
        test_step_pulsed();
        test_saturation();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bram_scan_sequencer
`default_nettype wire
